// File: rtl/cayde_alu_seq.sv
// cayde_alu_seq: request/response ALU.
// Single-cycle ops finish one cycle after acceptance. MUL, DIVU and REMU
// iterate one bit per cycle for WIDTH cycles. Results are held in DONE
// until the consumer takes them.
module cayde_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] res_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  // WIDTH is a power of two, so the last iteration index is all ones.
  localparam logic [SHW-1:0] CNT_LAST = '1;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  // a: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
  // b: multiplier (MUL) or divisor (DIV)
  // acc: product (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             is_iter;

  logic [WIDTH-1:0] mul_acc_nx, mul_a_nx, mul_b_nx;
  logic [WIDTH:0]   div_trial, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_q_nx;

  assign shamt   = op_b_i[SHW-1:0];
  assign is_iter = (op_i == OP_MUL) || (op_i == OP_DIVU) || (op_i == OP_REMU);

  // Single-cycle result, computed straight from the request inputs.
  always_comb begin
    alu_res = '0;
    case (op_i)
      OP_ADD:  alu_res = op_a_i + op_b_i;
      OP_SUB:  alu_res = op_a_i - op_b_i;
      OP_XOR:  alu_res = op_a_i ^ op_b_i;
      OP_AND:  alu_res = op_a_i & op_b_i;
      OP_OR:   alu_res = op_a_i | op_b_i;
      OP_NOT:  alu_res = ~op_a_i;
      OP_SLL:  alu_res = op_a_i << shamt;
      OP_SRL:  alu_res = op_a_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a_i) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step.
  // A zero divisor always "fits", so the quotient fills with ones and the
  // remainder register ends up holding the dividend without special casing.
  always_comb begin
    mul_acc_nx = b_q[0] ? (acc_q + a_q) : acc_q;
    mul_a_nx   = a_q << 1;
    mul_b_nx   = b_q >> 1;
    div_trial  = {acc_q, a_q[WIDTH-1]};
    div_sub    = div_trial - {1'b0, b_q};
    div_ge     = (div_trial >= {1'b0, b_q});
    div_rem_nx = div_ge ? div_sub[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_q_nx   = {a_q[WIDTH-2:0], div_ge};
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d  = op_i;
          a_d   = op_a_i;
          b_d   = op_b_i;
          acc_d = '0;
          cnt_d = '0;
          if (is_iter) begin
            state_d = BUSY;
          end else begin
            res_d   = alu_res;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nx;
          a_d   = mul_a_nx;
          b_d   = mul_b_nx;
        end else begin
          acc_d = div_rem_nx;
          a_d   = div_q_nx;
        end
        // Last step lands its value straight in the result register.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (op_q == OP_MUL)       res_d = mul_acc_nx;
          else if (op_q == OP_DIVU) res_d = div_q_nx;
          else                      res_d = div_rem_nx;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
          res_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign res_o       = out_valid_o ? res_q : '0;

endmodule

// File: tb/tb_cayde_alu_seq.sv
// Self-checking bench for cayde_alu_seq at WIDTH=32.
module tb_cayde_alu_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [W-1:0]  op_a, op_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  res;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cayde_alu_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .op_a_i(op_a), .op_b_i(op_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res)
  );

  // Reference behaviour from the opcode table.
  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a ^ b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return ~a;
      4'd6:  return a << s;
      4'd7:  return a >> s;
      4'd8:  return $signed(a) >>> s;
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
      4'd11: return a * b;
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] o);
    return (o == 4'd11 || o == 4'd12 || o == 4'd13) ? W + 1 : 1;
  endfunction

  // Drive one request, scramble inputs after acceptance, wait for the result
  // and take it. lat = 999 means it never got accepted or never completed.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output int lat, output bit zero_ok, output bit rdy_ok);
    int guard;
    zero_ok = 1; rdy_ok = 1; lat = 999; r = '0;
    @(negedge clk);
    in_valid = 1; op = o; op_a = a; op_b = b;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!in_ready) begin in_valid = 0; return; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; op = 4'($urandom); op_a = $urandom; op_b = $urandom;
    for (int c = 1; c < 200; c++) begin
      if (out_valid) begin lat = c; r = res; break; end
      if (res !== '0) zero_ok = 0;
      if (in_ready !== 1'b0) rdy_ok = 0;
      @(negedge clk);
    end
    if (lat == 999) return;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; op = 4'd0; op_a = 32'd1; op_b = 32'd2; out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; in_valid = 0;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (res !== '0) begin n_fail++; $display("FAIL reset_res: got %h want 0", res); end
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_no_accept: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [3:0]   ops [12] = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd9, 4'd10, 4'd11, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13};
    logic [W-1:0] as  [12] = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd7, 32'h0001_0000, 32'd100, 32'd100, 32'd100, 32'd100};
    logic [W-1:0] bs  [12] = '{32'd1, 32'd1, 32'h24, 32'h24, 32'd1, 32'd1, 32'd6, 32'h0001_0000, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] ex  [12] = '{32'h0, 32'hFFFF_FFFF, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0,
                               32'd42, 32'd0, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100};
    logic [W-1:0] r;
    int lat;
    bit zok, rok;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], r, lat, zok, rok);
      n_chk++; if (r !== ex[i]) begin n_fail++; $display("FAIL dir_res[%0d] op %0d: got %h want %h", i, ops[i], r, ex[i]); end
      n_chk++; if (lat != exp_lat(ops[i])) begin n_fail++; $display("FAIL dir_lat[%0d] op %0d: got %0d want %0d", i, ops[i], lat, exp_lat(ops[i])); end
      n_chk++; if (!zok) begin n_fail++; $display("FAIL dir_res_zero[%0d]: res nonzero while out_valid low, want 0", i); end
      n_chk++; if (!rok) begin n_fail++; $display("FAIL dir_busy_ready[%0d]: in_ready high while busy, want 0", i); end
    end
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] a, b, r, e;
    int lat;
    bit zok, rok;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      e = model(o, a, b);
      run_op(o, a, b, r, lat, zok, rok);
      n_chk++; if (r !== e || lat != exp_lat(o)) begin
        n_fail++; $display("FAIL rand[%0d] op %0d a %h b %h: got %h lat %0d want %h lat %0d", i, o, a, b, r, lat, e, exp_lat(o));
      end
      n_chk++; if (!zok || !rok) begin n_fail++; $display("FAIL rand_idle_out[%0d]: zero_ok %b ready_ok %b want 1/1", i, zok, rok); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid = 1; op = 4'd0; op_a = 32'd3; op_b = 32'd4; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    n_chk++; if (out_valid !== 1'b1 || res !== 32'd7) begin n_fail++; $display("FAIL bp_first: valid %b res %h want 1/7", out_valid, res); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; op = 4'd1; op_a = 32'd100; op_b = 32'd1;
      @(negedge clk);
      n_chk++; if (res !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: res %h valid %b ready %b want 7/1/0", i, res, out_valid, in_ready);
      end
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== '0) begin
      n_fail++; $display("FAIL bp_release: ready %b valid %b res %h want 1/0/0", in_ready, out_valid, res);
    end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_req: valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    logic [W-1:0] r;
    int lat;
    bit zok, rok;
    @(negedge clk);
    in_valid = 1; op = 4'd12; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_busy: ready %b want 0", in_ready); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== '0) begin
      n_fail++; $display("FAIL abort_state: ready %b valid %b res %h want 1/0/0", in_ready, out_valid, res);
    end
    seen = 0;
    out_ready = 1;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1; end
    out_ready = 0;
    n_chk++; if (seen) begin n_fail++; $display("FAIL abort_no_result: result appeared, want none"); end
    run_op(4'd0, 32'd5, 32'd6, r, lat, zok, rok);
    n_chk++; if (r !== 32'd11 || lat != 1) begin n_fail++; $display("FAIL abort_fresh_add: got %h lat %0d want 0000000b lat 1", r, lat); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   o;
    logic [W-1:0] a, b, r, e;
    int lat;
    bit zok, rok;
    for (int i = 0; i < 6; i++) begin
      o = (i % 2 == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 13));
      a = $urandom; b = $urandom;
      e = model(o, a, b);
      run_op(o, a, b, r, lat, zok, rok);
      n_chk++; if (r !== e) begin n_fail++; $display("FAIL b2b_res[%0d] op %0d: got %h want %h", i, o, r, e); end
      n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_after_xfer[%0d]: ready %b valid %b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; op = '0; op_a = '0; op_b = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
